// File: rtl/multicycle_ctrl_if.sv
// Instruction/data bus handshake between the multicycle sequencer (master) and the memory side (slave).
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with bus timeout and sticky fault.
// Optional feature: define ILLEGAL_TRAP_EN to trap instr_type 7 as an illegal opcode instead of a NOP.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5,
  parameter int RET_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus,
  input  logic [2:0]       i_instr_type,
  input  logic             i_save_to_reg,
  input  logic             i_rd_memory,
  input  logic             i_wr_memory,
  input  logic             i_is_branch,
  input  logic             i_branch_taken,
  output logic             o_ir_en,
  output logic             o_alu_en,
  output logic             o_rf_we,
  output logic             o_pc_en,
  output logic             o_pc_sel,
  output logic             o_retire,
  output logic [RET_W-1:0] o_retired_cnt,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [RET_W-1:0] RET_ONE = RET_W'(1);
  localparam logic [1:0]       FC_BUS  = 2'd1;
  localparam logic [1:0]       FC_ILL  = 2'd2;

  state_t           r_state;
  state_t           w_nextState;
  logic [TO_W-1:0]  r_toCnt;
  logic [RET_W-1:0] r_retiredCnt;
  logic             r_fault;
  logic [1:0]       r_faultCode;
  logic [1:0]       w_faultCause;
  logic             w_toExpired;
  logic             w_wbNop;
  logic             w_busWait;

`ifdef ILLEGAL_TRAP_EN
  assign w_wbNop = 1'b0;
`else
  logic r_nop;

  // A type-7 instruction skips EXEC and must not write the regfile or take a target in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nop <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_nop <= (i_instr_type == 3'd7);
    end
  end

  assign w_wbNop = r_nop;
`endif

  assign w_toExpired = (r_toCnt == TO_LAST);
  assign w_busWait   = ((r_state == S_FETCH) && !bus.imem_ready) ||
                       ((r_state == S_MEM)   && !bus.dmem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_faultCause = 2'd0;
    case (r_state)
      S_IDLE: begin
        w_nextState = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          w_nextState = S_DECODE;
        end else if (w_toExpired) begin
          w_nextState  = S_FAULT;
          w_faultCause = FC_BUS;
        end
      end
      S_DECODE: begin
        if (i_instr_type == 3'd7) begin
`ifdef ILLEGAL_TRAP_EN
          w_nextState  = S_FAULT;
          w_faultCause = FC_ILL;
`else
          w_nextState  = S_WB;
`endif
        end else begin
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        w_nextState = (i_rd_memory || i_wr_memory) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          w_nextState = S_WB;
        end else if (w_toExpired) begin
          w_nextState  = S_FAULT;
          w_faultCause = FC_BUS;
        end
      end
      S_WB: begin
        w_nextState = S_FETCH;
      end
      S_FAULT: begin
        w_nextState = S_FAULT;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Strobes follow the registered state, so an async reset drops them (including bus requests) at once.
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    o_ir_en      = 1'b0;
    o_alu_en     = 1'b0;
    o_rf_we      = 1'b0;
    o_pc_en      = 1'b0;
    o_pc_sel     = 1'b0;
    o_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        o_ir_en      = bus.imem_ready;
      end
      S_EXEC: begin
        o_alu_en = 1'b1;
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = i_wr_memory;
      end
      S_WB: begin
        o_rf_we  = (i_save_to_reg || i_rd_memory) && !w_wbNop;
        o_pc_en  = 1'b1;
        o_pc_sel = i_is_branch && ((i_instr_type != 3'd3) || i_branch_taken) && !w_wbNop;
        o_retire = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Idling outside FETCH/MEM keeps the counter at zero, which is what clears it on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt <= '0;
    end else if (w_busWait) begin
      r_toCnt <= r_toCnt + TO_ONE;
    end else begin
      r_toCnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retiredCnt <= '0;
    end else if (r_state == S_WB) begin
      r_retiredCnt <= r_retiredCnt + RET_ONE;
    end
  end

  // The fault cause is captured only on the transition into FAULT and then held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault     <= 1'b0;
      r_faultCode <= 2'd0;
    end else if ((w_nextState == S_FAULT) && (r_state != S_FAULT)) begin
      r_fault     <= 1'b1;
      r_faultCode <= w_faultCause;
    end
  end

  assign o_retired_cnt = r_retiredCnt;
  assign o_fault       = r_fault;
  assign o_fault_code  = r_faultCode;
  assign o_state       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, random instruction stream, timeout/reset corners.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;
  localparam int RET_W   = 32;
  localparam int N_RAND  = 150;

  typedef struct {
    logic [2:0] itype;
    logic       save;
    logic       rd;
    logic       wr;
    logic       br;
    logic       taken;
    int         fw;
    int         mw;
    logic       expRfWe;
    logic       expPcSel;
  } instrVec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] instrType = 3'd0;
  logic saveToReg = 1'b0, rdMemory = 1'b0, wrMemory = 1'b0, isBranch = 1'b0, branchTaken = 1'b0;
  logic irEn, aluEn, rfWe, pcEn, pcSel, retire, fault;
  logic [RET_W-1:0] retiredCnt;
  logic [1:0] faultCode;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int expRetired = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(TO_W), .RET_W(RET_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_instr_type(instrType),
    .i_save_to_reg(saveToReg),
    .i_rd_memory(rdMemory),
    .i_wr_memory(wrMemory),
    .i_is_branch(isBranch),
    .i_branch_taken(branchTaken),
    .o_ir_en(irEn),
    .o_alu_en(aluEn),
    .o_rf_we(rfWe),
    .o_pc_en(pcEn),
    .o_pc_sel(pcSel),
    .o_retire(retire),
    .o_retired_cnt(retiredCnt),
    .o_fault(fault),
    .o_fault_code(faultCode),
    .o_state(state)
  );

  // Output vector layout: {state, imem_req, ir_en, alu_en, dmem_req, dmem_we, rf_we, pc_en, pc_sel, retire}
  function automatic logic [11:0] mkVec(input logic [2:0] st, input logic ireq, input logic ir, input logic alu,
                                        input logic dreq, input logic dwe, input logic rf, input logic pce,
                                        input logic pcs, input logic ret);
    return {st, ireq, ir, alu, dreq, dwe, rf, pce, pcs, ret};
  endfunction

  function automatic logic [11:0] actualVec();
    return {state, bus.imem_req, irEn, aluEn, bus.dmem_req, bus.dmem_we, rfWe, pcEn, pcSel, retire};
  endfunction

  function automatic bit isNop(input logic [2:0] t);
`ifdef ILLEGAL_TRAP_EN
    return 1'b0;
`else
    return (t == 3'd7);
`endif
  endfunction

  function automatic bit usesMem(input instrVec_t v);
    return (v.rd || v.wr) && !isNop(v.itype);
  endfunction

  // Reference: an instruction spends fw+1 cycles in FETCH, one in DECODE, then EXEC, optional MEM, WB.
  function automatic int modelLen(input instrVec_t v);
    if (isNop(v.itype)) return v.fw + 3;
    return v.fw + 4 + (usesMem(v) ? v.mw + 1 : 0);
  endfunction

  function automatic logic [11:0] modelCycle(input instrVec_t v, input int k);
    int memStart;
    memStart = v.fw + 3;
    if (k <= v.fw) return mkVec(3'd1, 1'b1, (k == v.fw), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (k == v.fw + 1) return mkVec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (isNop(v.itype)) return mkVec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.expRfWe, 1'b1, v.expPcSel, 1'b1);
    if (k == v.fw + 2) return mkVec(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (usesMem(v) && k <= memStart + v.mw)
      return mkVec(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, v.wr, 1'b0, 1'b0, 1'b0, 1'b0);
    return mkVec(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v.expRfWe, 1'b1, v.expPcSel, 1'b1);
  endfunction

  function automatic instrVec_t modelWb(input instrVec_t v);
    instrVec_t r;
    r = v;
    r.expRfWe  = isNop(v.itype) ? 1'b0 : (v.save || v.rd);
    r.expPcSel = isNop(v.itype) ? 1'b0 : (v.br && ((v.itype != 3'd3) || v.taken));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic setDecode(input instrVec_t v);
    instrType   = v.itype;
    saveToReg   = v.save;
    rdMemory    = v.rd;
    wrMemory    = v.wr;
    isBranch    = v.br;
    branchTaken = v.taken;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.imem_ready = 1'($urandom);
    bus.dmem_ready = 1'($urandom);
    repeat (2) begin
      @(negedge clk);
      checkOutput("reset strobes", actualVec(), 64'(mkVec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      checkOutput("reset status", {retiredCnt, fault, faultCode}, '0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.imem_ready = 1'($urandom);
    @(negedge clk);
    checkOutput("idle strobes", actualVec(), 64'(mkVec(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    expRetired = 0;
  endtask

  // Runs one instruction from its first FETCH cycle through WB, checking every cycle against the model.
  task automatic applyStimulus(input instrVec_t v, input string tag);
    int len;
    int memStart;
    len      = modelLen(v);
    memStart = v.fw + 3;
    setDecode(v);
    for (int k = 0; k < len; k++) begin
      bus.imem_ready = (k <= v.fw) ? (k == v.fw) : 1'($urandom);
      if (usesMem(v) && k >= memStart && k <= memStart + v.mw) bus.dmem_ready = (k == memStart + v.mw);
      else bus.dmem_ready = 1'($urandom);
      @(negedge clk);
      checkOutput($sformatf("%s cyc%0d", tag, k), actualVec(), 64'(modelCycle(v, k)));
      @(posedge clk); #1;
    end
    expRetired++;
    checkOutput($sformatf("%s retired_cnt", tag), retiredCnt, expRetired);
  endtask

  // Bus never answers (or an illegal opcode arrives): run preFault cycles, then expect an absorbing FAULT.
  task automatic runToFault(input instrVec_t v, input int preFault, input logic [1:0] code, input string tag);
    setDecode(v);
    for (int k = 0; k < preFault; k++) begin
      bus.imem_ready = (k == v.fw);
      bus.dmem_ready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("%s cyc%0d", tag, k), actualVec(), 64'(modelCycle(v, k)));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      @(negedge clk);
      checkOutput($sformatf("%s fault strobes %0d", tag, k), actualVec(),
                  64'(mkVec(3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      checkOutput($sformatf("%s fault status %0d", tag, k), {fault, faultCode}, {1'b1, code});
      checkOutput($sformatf("%s fault retired", tag), retiredCnt, expRetired);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    instrVec_t tbl[10];
    instrVec_t v;
    int nVec;

    //           type  sv rd wr br tk fw  mw  rf pcs
    tbl[0] = '{3'd0, 1, 0, 0, 0, 0, 0,  0,  1, 0};
    tbl[1] = '{3'd1, 1, 1, 0, 0, 0, 0,  3,  1, 0};
    tbl[2] = '{3'd2, 0, 0, 1, 0, 0, 2,  1,  0, 0};
    tbl[3] = '{3'd3, 0, 0, 0, 1, 0, 0,  0,  0, 0};
    tbl[4] = '{3'd3, 0, 0, 0, 1, 1, 1,  0,  0, 1};
    tbl[5] = '{3'd5, 1, 0, 0, 1, 0, 0,  0,  1, 1};
    tbl[6] = '{3'd1, 1, 0, 0, 0, 1, 15, 0,  1, 0};
    tbl[7] = '{3'd1, 0, 1, 0, 0, 0, 0,  15, 1, 0};
    tbl[8] = '{3'd4, 1, 0, 0, 0, 1, 3,  0,  1, 0};
    tbl[9] = '{3'd7, 1, 1, 0, 1, 1, 0,  0,  0, 0};
`ifdef ILLEGAL_TRAP_EN
    nVec = 9;
`else
    nVec = 10;
`endif

    doReset();
    for (int i = 0; i < nVec; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < N_RAND; i++) begin
      v.itype = 3'($urandom_range(0, 6));
      if (v.itype == 3'd6) v.itype = 3'd7;
`ifdef ILLEGAL_TRAP_EN
      if (v.itype == 3'd7) v.itype = 3'd0;
`endif
      v.save  = 1'($urandom);
      v.rd    = 1'($urandom);
      v.wr    = 1'($urandom);
      v.br    = 1'($urandom);
      v.taken = 1'($urandom);
      v.fw    = $urandom_range(0, TIMEOUT - 1);
      v.mw    = $urandom_range(0, TIMEOUT - 1);
      v = modelWb(v);
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    // Reset asserted mid-MEM must drop dmem_req immediately and clear the retire count.
    v = modelWb('{3'd2, 0, 0, 1, 0, 0, 0, 20, 0, 0});
    setDecode(v);
    for (int k = 0; k < 5; k++) begin
      bus.imem_ready = (k == 0);
      bus.dmem_ready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("rstmem cyc%0d", k), actualVec(), 64'(modelCycle(v, k)));
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("rstmem retired before", retiredCnt, expRetired);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmem dmem_req", bus.dmem_req, 1'b0);
    checkOutput("rstmem state", state, 3'd0);
    checkOutput("rstmem retired", retiredCnt, 0);

    doReset();
    v = modelWb('{3'd0, 1, 0, 0, 0, 0, 40, 0, 0, 0});
    runToFault(v, TIMEOUT, 2'd1, "fetchto");

    doReset();
    v = modelWb('{3'd2, 0, 0, 1, 0, 0, 0, 40, 0, 0});
    runToFault(v, 3 + TIMEOUT, 2'd1, "memto");

`ifdef ILLEGAL_TRAP_EN
    doReset();
    applyStimulus(tbl[0], "preill");
    v = '{3'd7, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    runToFault(v, 2, 2'd2, "illegal");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
